// File: rtl/fetch_arb_pkg.sv
// rtl/fetch_arb_pkg.sv - shared types and command encodings for the fetch arbiter
//
// Contents:
//   fetch_arb_state_t   arbiter FSM states (IDLE, ISSUE, WAIT_DONE)
//   FETCH_CMD_FETCH     plain line fill
//   FETCH_CMD_WB_FETCH  writeback of the victim line followed by a fill
package fetch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } fetch_arb_state_t;

    localparam logic [1:0] FETCH_CMD_FETCH    = 2'b01;
    localparam logic [1:0] FETCH_CMD_WB_FETCH = 2'b10;

endpackage

// File: rtl/fetch_arb_rr_pick.sv
// rtl/fetch_arb_rr_pick.sv - combinational round-robin / fixed-priority picker
//
// Macro: FETCH_ARB_FIXED_PRI_EN selects fixed priority (lowest index wins, ptr ignored).
// Ports:
//   req  in   num_req  request vector
//   ptr  in   iw       index where the round-robin search starts
//   gnt  out  num_req  one-hot winner (all zero when no request)
//   idx  out  iw       index of the winner
//   any  out  1        at least one request is present
module rr_pick #(
    parameter int num_req = 2,
    parameter int iw      = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic [num_req-1:0] req,
    input  logic [iw-1:0]      ptr,
    output logic [num_req-1:0] gnt,
    output logic [iw-1:0]      idx,
    output logic               any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < num_req; k++) begin
`ifdef FETCH_ARB_FIXED_PRI_EN
            cand = k;
`else
            // Walk upward from ptr and wrap, so ptr itself has top priority.
            cand = (int'(ptr) + k) % num_req;
`endif
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand[iw-1:0];
            end
        end
    end

`ifdef FETCH_ARB_FIXED_PRI_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/fetch_arb.sv
// rtl/fetch_arb.sv - arbiter sharing one line-fill engine between rd/wr controllers
//
// Macro: FETCH_ARB_FIXED_PRI_EN selects fixed priority instead of round robin.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/cmd/tag/addr/addr_pre   per-requester fetch request (0 = rd, 1 = wr)
//   req_gnt, req_done        one-hot pulses back to the owning requester
//   bus_req/cmd/tag/addr/addr_pre     request to the fetch engine (payload 0 unless ISSUE)
//   bus_gnt, bus_done        engine accept and completion
//   busy, owner              FSM not idle; index of the current owner
module fetch_arb
    import fetch_arb_pkg::*;
#(
    parameter int  num_req    = 2,
    parameter int  addr_width = 32,
    parameter int  list_depth = 4,
    localparam int TW         = $clog2(list_depth),
    localparam int OW         = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_valid,
    input  logic [2*num_req-1:0]          req_cmd,
    input  logic [TW*num_req-1:0]         req_tag,
    input  logic [addr_width*num_req-1:0] req_addr,
    input  logic [addr_width*num_req-1:0] req_addr_pre,
    output logic [num_req-1:0]            req_gnt,
    output logic [num_req-1:0]            req_done,
    output logic                          bus_req,
    output logic [1:0]                    bus_cmd,
    output logic [TW-1:0]                 bus_tag,
    output logic [addr_width-1:0]         bus_addr,
    output logic [addr_width-1:0]         bus_addr_pre,
    input  logic                          bus_gnt,
    input  logic                          bus_done,
    output logic                          busy,
    output logic [OW-1:0]                 owner
);

    fetch_arb_state_t   state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      pick_ptr, pick_idx;
    logic [num_req-1:0] pick_gnt_unused;
    logic               pick_any;

`ifdef FETCH_ARB_FIXED_PRI_EN
    assign pick_ptr = '0;
`else
    logic [OW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] owner_inc;

    assign owner_inc = (int'(owner_q) == num_req - 1) ? '0 : owner_q + 1'b1;
    // On completion the arbitration must already see the advanced pointer,
    // otherwise a back-to-back re-arbitration would favour the old owner.
    assign pick_ptr  = (state_q == WAIT_DONE) ? owner_inc : ptr_q;
`endif

    rr_pick #(
        .num_req (num_req),
        .iw      (OW)
    ) u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .gnt (pick_gnt_unused),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
`ifndef FETCH_ARB_FIXED_PRI_EN
        ptr_d        = ptr_q;
`endif
        req_gnt      = '0;
        req_done     = '0;
        bus_req      = 1'b0;
        bus_cmd      = '0;
        bus_tag      = '0;
        bus_addr     = '0;
        bus_addr_pre = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                for (int i = 0; i < num_req; i++) begin
                    if (int'(owner_q) == i) begin
                        bus_cmd      = req_cmd[2*i +: 2];
                        bus_tag      = req_tag[TW*i +: TW];
                        bus_addr     = req_addr[addr_width*i +: addr_width];
                        bus_addr_pre = req_addr_pre[addr_width*i +: addr_width];
                    end
                end
                bus_req = req_valid[owner_q];
                if (!req_valid[owner_q]) begin
                    // Requester withdrew before the engine took it: drop it silently.
                    state_d = IDLE;
                end else if (bus_gnt) begin
                    req_gnt[owner_q] = 1'b1;
                    state_d          = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus_done) begin
                    req_done[owner_q] = 1'b1;
`ifndef FETCH_ARB_FIXED_PRI_EN
                    ptr_d             = owner_inc;
`endif
                    if (pick_any) begin
                        owner_d = pick_idx;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifndef FETCH_ARB_FIXED_PRI_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_fetch_arb.sv
// tb/tb_fetch_arb.sv - scoreboard bench for fetch_arb with a transaction-level reference model
module tb_fetch_arb;
    import fetch_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int TW = 2;
    localparam int OW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_cmd;
    logic [TW*N-1:0] req_tag;
    logic [AW*N-1:0] req_addr;
    logic [AW*N-1:0] req_addr_pre;
    logic [N-1:0]    req_gnt;
    logic [N-1:0]    req_done;
    logic            bus_req;
    logic [1:0]      bus_cmd;
    logic [TW-1:0]   bus_tag;
    logic [AW-1:0]   bus_addr;
    logic [AW-1:0]   bus_addr_pre;
    logic            bus_gnt;
    logic            bus_done;
    logic            busy;
    logic [OW-1:0]   owner;

    fetch_arb #(.num_req(N), .addr_width(AW), .list_depth(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_tag      (req_tag),
        .req_addr     (req_addr),
        .req_addr_pre (req_addr_pre),
        .req_gnt      (req_gnt),
        .req_done     (req_done),
        .bus_req      (bus_req),
        .bus_cmd      (bus_cmd),
        .bus_tag      (bus_tag),
        .bus_addr     (bus_addr),
        .bus_addr_pre (bus_addr_pre),
        .bus_gnt      (bus_gnt),
        .bus_done     (bus_done),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [AW-1:0] pre;
    } fetch_t;

    fetch_t req_q [N][$];   // pending payload per requester
    int     done_q [$];     // owners with a fetch in flight
    int     grant_log [$];
    int     gnt_count [N];
    int     done_count [N];
    bit     hs_seen [N];
    bit     eng_start = 1'b0;
    int     eng_cnt   = 0;
    int     tests = 0;
    int     fails = 0;

    // Reference model: idle / issuing / waiting, with the owner and rr pointer.
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 0;

    int p_new = 0, p_gnt = 100, dly_min = 1, dly_max = 1, p_wd = 0, p_spur = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int p);
        int start;
        start = p;
`ifdef FETCH_ARB_FIXED_PRI_EN
        start = 0;
`endif
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    // Monitor: compares DUT outputs to the model mid-cycle, then advances the model.
    always @(negedge clk) begin
        fetch_t       exp_p;
        logic         exp_req;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_done;
        #2;
        exp_p    = '0;
        exp_req  = 1'b0;
        exp_gnt  = '0;
        exp_done = '0;
        if (rst) begin
            check("rst_ctrl", {bus_req, req_gnt, req_done, busy, owner, bus_cmd, bus_tag}, '0);
            check("rst_addr", {bus_addr, bus_addr_pre}, '0);
            m_phase = 0;
            m_owner = 0;
            m_ptr   = 0;
            done_q.delete();
        end else begin
            if (m_phase == 1 && req_valid[m_owner]) begin
                exp_req = 1'b1;
                if (req_q[m_owner].size() > 0) exp_p = req_q[m_owner][0];
                if (bus_gnt) exp_gnt[m_owner] = 1'b1;
            end
            if (m_phase == 2 && bus_done && done_q.size() > 0) exp_done[done_q[0]] = 1'b1;

            check("busy", busy, m_phase != 0);
            if (m_phase != 0) check("owner", owner, m_owner);
            check("bus_req", bus_req, exp_req);
            if (!(m_phase == 1 && !req_valid[m_owner])) begin
                check("payload_cmd_tag", {bus_cmd, bus_tag}, {exp_p.cmd, exp_p.tag});
                check("payload_addr", {bus_addr, bus_addr_pre}, {exp_p.addr, exp_p.pre});
            end
            check("req_gnt", req_gnt, exp_gnt);
            check("req_done", req_done, exp_done);

            for (int i = 0; i < N; i++) begin
                if (req_gnt[i]) begin
                    gnt_count[i]++;
                    grant_log.push_back(i);
                    hs_seen[i] = 1'b1;
                end
                if (req_done[i]) done_count[i]++;
            end
            if (bus_req && bus_gnt) eng_start = 1'b1;

            case (m_phase)
                0: if (|req_valid) begin
                    m_owner = pick(req_valid, m_ptr);
                    m_phase = 1;
                end
                1: if (!req_valid[m_owner]) begin
                    m_phase = 0;
                end else if (bus_gnt) begin
                    m_phase = 2;
                    done_q.push_back(m_owner);
                    if (req_q[m_owner].size() > 0) void'(req_q[m_owner].pop_front());
                end
                2: if (bus_done) begin
                    if (done_q.size() > 0) void'(done_q.pop_front());
                    m_ptr = (m_owner + 1) % N;
                    if (|req_valid) begin
                        m_owner = pick(req_valid, m_ptr);
                        m_phase = 1;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    function automatic fetch_t rand_payload();
        fetch_t p;
        p.cmd  = ($urandom_range(1, 0) == 0) ? FETCH_CMD_FETCH : FETCH_CMD_WB_FETCH;
        p.tag  = TW'($urandom);
        p.addr = $urandom;
        p.pre  = $urandom;
        return p;
    endfunction

    task automatic launch(int i, fetch_t p);
        req_valid[i]           = 1'b1;
        req_cmd[2*i +: 2]      = p.cmd;
        req_tag[TW*i +: TW]    = p.tag;
        req_addr[AW*i +: AW]   = p.addr;
        req_addr_pre[AW*i +: AW] = p.pre;
        req_q[i].push_back(p);
    endtask

    // One cycle of requester and engine behaviour, driven at the falling edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs_seen[i]) begin
                hs_seen[i]   = 1'b0;
                req_valid[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
                if ($urandom_range(99, 0) < p_new) launch(i, rand_payload());
            end else if ($urandom_range(99, 0) < p_wd) begin
                req_valid[i] = 1'b0;
                req_q[i].delete();
            end
        end
        if (eng_start) begin
            eng_start = 1'b0;
            eng_cnt   = $urandom_range(dly_max, dly_min);
        end
        bus_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) bus_done = 1'b1;
        end else if ($urandom_range(99, 0) < p_spur) begin
            bus_done = 1'b1;
        end
        bus_gnt = ($urandom_range(99, 0) < p_gnt);
    endtask

    task automatic assert_reset();
        rst       = 1'b1;
        req_valid = '0;
        bus_gnt   = 1'b0;
        bus_done  = 1'b0;
        eng_cnt   = 0;
        eng_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_q[i].delete();
            hs_seen[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        assert_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            gnt_count[i]  = 0;
            done_count[i] = 0;
        end
    endtask

    initial begin
        fetch_t p;
        int     exp_order [4];
        int     exp_after_wd;
        bit     reached;

`ifdef FETCH_ARB_FIXED_PRI_EN
        exp_order    = '{0, 0, 0, 0};
        exp_after_wd = 0;
`else
        exp_order    = '{0, 1, 0, 1};
        exp_after_wd = 1;
`endif
        rst          = 1'b1;
        req_valid    = '0;
        req_cmd      = '0;
        req_tag      = '0;
        req_addr     = '0;
        req_addr_pre = '0;
        bus_gnt      = 1'b0;
        bus_done     = 1'b0;
        do_reset();

        // Single request from the write controller, grant held high, done 5 cycles later.
        clear_counts();
        p_new = 0; p_gnt = 100; dly_min = 5; dly_max = 5; p_wd = 0; p_spur = 0;
        @(negedge clk);
        p.cmd = FETCH_CMD_WB_FETCH; p.tag = 2'd3; p.addr = 32'h100; p.pre = 32'h200;
        bus_gnt = 1'b1;
        launch(1, p);
        repeat (12) step();
        check("single_gnt1", gnt_count[1], 1);
        check("single_done1", done_count[1], 1);
        check("single_gnt0", gnt_count[0], 0);

        // Stalled grant: engine refuses for 4 cycles while the request is presented.
        clear_counts();
        p_gnt = 0;
        @(negedge clk);
        bus_gnt = 1'b0;
        launch(0, rand_payload());
        repeat (4) step();
        check("stall_no_gnt", gnt_count[0], 0);
        p_gnt = 100;
        repeat (12) step();
        check("stall_gnt", gnt_count[0], 1);

        // Withdrawal in ISSUE, then both request to show the pointer did not move.
        clear_counts();
        @(negedge clk);
        bus_gnt = 1'b0;
        launch(0, rand_payload());
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_q[0].delete();
        bus_gnt = 1'b1;
        repeat (3) step();
        check("withdraw_no_gnt", gnt_count[0], 0);
        dly_min = 2; dly_max = 2;
        @(negedge clk);
        launch(0, rand_payload());
        launch(1, rand_payload());
        repeat (15) step();
        check("after_withdraw_len", grant_log.size() >= 1, 1);
        if (grant_log.size() >= 1) check("after_withdraw_winner", grant_log[0], exp_after_wd);

        // Contention from reset with both controllers re-requesting continuously.
        do_reset();
        clear_counts();
        p_new = 100; dly_min = 1; dly_max = 4;
        @(negedge clk);
        bus_gnt = 1'b1;
        launch(0, rand_payload());
        launch(1, rand_payload());
        repeat (30) step();
        check("contention_len", grant_log.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (grant_log.size() > k) check("contention_order", grant_log[k], exp_order[k]);

        // Randomized traffic with stalls, withdrawals and spurious completions.
        p_new = 40; p_gnt = 60; dly_min = 1; dly_max = 6; p_wd = 3; p_spur = 10;
        repeat (2000) step();

        // Reset while waiting for completion; the late bus_done must be dropped.
        do_reset();
        clear_counts();
        p_new = 0; p_gnt = 100; dly_min = 8; dly_max = 8; p_wd = 0; p_spur = 0;
        @(negedge clk);
        bus_gnt = 1'b1;
        launch(0, rand_payload());
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_phase == 2) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_wait_done", reached, 1);
        assert_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        p_spur = 100;
        repeat (3) step();
        check("done_after_reset", done_count[0] + done_count[1], 0);
        p_spur = 0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
